// File: rtl/seq_tx.sv
// Pattern serializer: sends a captured pattern MSB first, R times, with an
// optional idle gap between repetitions and a programmable bit period.
module seq_tx #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 4,
  parameter int               DIV_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b0111)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_def,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [3:0]       gap,
  input  logic [DIV_W-1:0] bit_div,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] sr_q;
  logic [DIV_W-1:0] div_cfg_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       gap_cfg_q;
  logic [3:0]       gap_q;
  logic [CNT_W-1:0] rep_q;
  logic [BIT_W-1:0] bit_q;

  logic [PAT_W-1:0] pat_d;
  logic [CNT_W-1:0] rep_d;

  // rep_q holds repetitions still to come after the current one.
  assign pat_d = use_def ? DEF_PAT : pattern;
  assign rep_d = (repeat_n == '0) ? '0 : repeat_n - CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      sr_q      <= '0;
      div_cfg_q <= '0;
      div_q     <= '0;
      gap_cfg_q <= '0;
      gap_q     <= '0;
      rep_q     <= '0;
      bit_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Outputs are a registered view of the state, one cycle behind it.
      out       <= (state_q == SHIFT) && sr_q[PAT_W-1];
      out_valid <= (state_q == SHIFT);
      busy      <= (state_q == SHIFT) || (state_q == GAP);
      done      <= (state_q == DONE);

      case (state_q)
        IDLE: begin
          if (start) begin
            pat_q     <= pat_d;
            sr_q      <= pat_d;
            div_cfg_q <= bit_div;
            gap_cfg_q <= gap;
            rep_q     <= rep_d;
            div_q     <= '0;
            bit_q     <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_q == div_cfg_q) begin
            div_q <= '0;
            if (bit_q == LAST_BIT) begin
              bit_q <= '0;
              if (rep_q == '0) begin
                state_q <= DONE;
              end else begin
                rep_q <= rep_q - CNT_W'(1);
                if (gap_cfg_q == 4'd0) begin
                  sr_q <= pat_q;
                end else begin
                  gap_q   <= gap_cfg_q - 4'd1;
                  state_q <= GAP;
                end
              end
            end else begin
              bit_q <= bit_q + BIT_W'(1);
              sr_q  <= sr_q << 1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        GAP: begin
          if (gap_q == 4'd0) begin
            sr_q    <= pat_q;
            state_q <= SHIFT;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// Randomized bench for seq_tx: each frame's expected output stream is built
// from the frame rules as a queue of {out, out_valid, busy, done} samples.
module tb_seq_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       use_def = 1'b0;
  logic [3:0] pattern = 4'd0;
  logic [3:0] repeat_n = 4'd0;
  logic [3:0] gap = 4'd0;
  logic [3:0] bit_div = 4'd0;
  logic       out;
  logic       out_valid;
  logic       busy;
  logic       done;

  int         n_vec = 0;
  int         n_err = 0;
  int         det_cnt = 0;
  logic [3:0] det_hist = 4'd0;

  always #5 clk = ~clk;

  seq_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .use_def  (use_def),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .gap      (gap),
    .bit_div  (bit_div),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  // Serial 0111 detector watching the valid bit stream.
  always @(negedge clk) begin
    if (out_valid) begin
      if ({det_hist[2:0], out} == 4'b0111) det_cnt = det_cnt + 1;
      det_hist = {det_hist[2:0], out};
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] obs();
    return {out, out_valid, busy, done};
  endfunction

  // Start a frame before the next edge and check every output cycle up to done.
  task automatic run_frame(input logic ud, input logic [3:0] pat, input logic [3:0] rn,
                           input logic [3:0] gp, input logic [3:0] bd, input bit junk,
                           input string name);
    logic [3:0] q[$];
    logic [3:0] p;
    int         r;
    int         errs0;
    p     = ud ? 4'b0111 : pat;
    r     = (rn == 4'd0) ? 1 : int'(rn);
    errs0 = n_err;
    q.push_back(4'b0000);
    for (int i = 0; i < r; i++) begin
      for (int b = 3; b >= 0; b--)
        for (int c = 0; c <= int'(bd); c++) q.push_back({p[b], 3'b110});
      if (i < r - 1)
        for (int g = 0; g < int'(gp); g++) q.push_back(4'b0010);
    end
    q.push_back(4'b0001);
    start    = 1'b1;
    use_def  = ud;
    pattern  = pat;
    repeat_n = rn;
    gap      = gp;
    bit_div  = bd;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("%s cyc%0d", name, i), {28'd0, obs()}, {28'd0, q[i]});
      if (junk) begin
        start    = 1'($urandom_range(0, 1));
        use_def  = 1'($urandom_range(0, 1));
        pattern  = 4'($urandom);
        repeat_n = 4'($urandom);
        gap      = 4'($urandom);
        bit_div  = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    $display("frame %s pat=%b R=%0d gap=%0d div=%0d cycles=%0d errors=%0d",
             name, p, r, gp, bd, q.size(), n_err - errs0);
  endtask

  initial begin
    #12;
    check_val("reset_outputs", {28'd0, obs()}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("idle_after_reset", {28'd0, obs()}, 32'd0);

    run_frame(1'b1, 4'b0000, 4'd1, 4'd0, 4'd0, 1'b0, "def_pat");
    run_frame(1'b0, 4'b1010, 4'd2, 4'd0, 4'd1, 1'b0, "no_gap");
    run_frame(1'b0, 4'b0111, 4'd3, 4'd2, 4'd0, 1'b0, "gap2");
    run_frame(1'b0, 4'b1101, 4'd0, 4'd3, 4'd0, 1'b1, "rep0_junk");
    run_frame(1'b0, 4'b1001, 4'd15, 4'd15, 4'd15, 1'b1, "max_counts");

    det_cnt  = 0;
    det_hist = 4'd0;
    run_frame(1'b1, 4'b1111, 4'd4, 4'd0, 4'd0, 1'b0, "detector");
    check_val("detections", det_cnt, 32'd4);

    // Abort during the third bit with an asynchronous reset.
    start    = 1'b1;
    use_def  = 1'b0;
    pattern  = 4'b1011;
    repeat_n = 4'd2;
    gap      = 4'd1;
    bit_div  = 4'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("abort_idle", {28'd0, obs()}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("abort_bit%0d", i), {28'd0, obs()}, {28'd0, pattern[3-i], 3'b110});
    end
    #2 rst = 1'b0;
    #1;
    check_val("async_reset", {28'd0, obs()}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_val("held_reset", {28'd0, obs()}, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("wait_start", {28'd0, obs()}, 32'd0);
    end
    run_frame(1'b0, 4'b1011, 4'd2, 4'd1, 4'd0, 1'b0, "after_abort");

    for (int t = 0; t < 30; t++) begin
      run_frame(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom_range(0, 3)), 1'b1, $sformatf("rand%0d", t));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        check_val("idle_between", {28'd0, obs()}, 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_tx.md
SEQ_TX -- requirements
Module: seq_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst.
REQ-002 Parameter PAT_W SHALL default to 4 and set the pattern width in bits.
REQ-003 Parameter CNT_W SHALL default to 4 and set the width of the repeat count.
REQ-004 Parameter DIV_W SHALL default to 4 and set the width of the bit-period divider.
REQ-005 Parameter DEF_PAT SHALL default to 4'b0111 and be the pattern used when use_def=1.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous reset, active-low.
REQ-008 start  in  1  request to transmit; sampled only in IDLE.
REQ-009 use_def  in  1  1 = send DEF_PAT, 0 = send pattern; sampled with start.
REQ-010 pattern  in  PAT_W  pattern to serialize, MSB first; sampled with start.
REQ-011 repeat_n  in  CNT_W  number of pattern transmissions; 0 SHALL be treated as 1.
REQ-012 gap  in  4  idle cycles between repetitions.
REQ-013 bit_div  in  DIV_W  each bit is held bit_div+1 cycles.
REQ-014 out  out  1  serial data bit.
REQ-015 out_valid  out  1  out carries a pattern bit this cycle.
REQ-016 busy  out  1  high during SHIFT and GAP.
REQ-017 done  out  1  one-cycle pulse when the final bit has completed.

Function
REQ-018 All outputs SHALL be registered; FSM states are IDLE, SHIFT, GAP and DONE.
REQ-019 IDLE: out=0, out_valid=0, busy=0, done=0; start=1 at an edge captures all config inputs and enters SHIFT at that edge.
REQ-020 Latency: start sampled at edge k SHALL give the first bit on out with out_valid=1 after edge k+1, held through edge k+1+bit_div.
REQ-021 SHIFT: out = MSB of the shift register, out_valid=1; on the last divider cycle of each bit, shift left by one.
REQ-022 After PAT_W bits with repetitions remaining and gap=0, the block SHALL reload the pattern and continue SHIFT with no bubble.
REQ-023 After PAT_W bits with repetitions remaining and gap>0, the block SHALL enter GAP for exactly gap cycles (out=0, out_valid=0, busy=1), then reload and return to SHIFT.
REQ-024 After the final bit, the block SHALL enter DONE for one cycle (done=1, busy=0, out_valid=0, out=0), then return to IDLE.
REQ-025 Total SHIFT+GAP duration SHALL be R*PAT_W*(bit_div+1) + (R-1)*gap cycles, where R = max(repeat_n, 1).
REQ-026 start SHALL be ignored in SHIFT, GAP and DONE; config input changes after capture SHALL have no effect.
REQ-027 The divider and repeat counters SHALL NOT wrap: repeat_n = 2^CNT_W-1 and bit_div = 2^DIV_W-1 SHALL be transmitted exactly.
REQ-028 start held continuously SHALL restart transmission on the edge after DONE, giving back-to-back frames with one IDLE cycle.

Reset
REQ-029 rst=0 SHALL immediately force IDLE: out=0, out_valid=0, busy=0, done=0, with all counters and the shift register cleared.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no done pulse; after rst is released, the block SHALL wait for a new start.

Verification
REQ-031 use_def=1, repeat_n=1, bit_div=0, start at edge 0 -> out=0,1,1,1 with valid after edges 1-4, done=1 after edge 5, busy=0 after edge 5.
REQ-032 pattern=4'b1010, use_def=0, repeat_n=2, gap=0, bit_div=1 -> 1,1,0,0,1,1,0,0,1,1,0,0,1,1,0,0 contiguous (16 cycles), then a single done pulse.
REQ-033 pattern=4'b0111, repeat_n=3, gap=2, bit_div=0 -> 0111, 2 idle cycles, 0111, 2 idle cycles, 0111; busy high for 16 cycles.
REQ-034 repeat_n=0 -> exactly one pattern is sent; a start pulse mid-frame -> no restart and no change in length.
REQ-035 rst pulsed low during the 3rd bit -> outputs go to 0 asynchronously with no done pulse; a later start sends a full frame.
REQ-036 out looped into a 0111 serial detector while sending DEF_PAT with repeat_n=4, gap=0 -> exactly 4 detections, one per frame at the last bit.
